// File: rtl/wb_pkg_hdl.sv
// Shared types and register-map constants for the Wishbone register responder.
package wb_pkg_hdl;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        RSP_ACK,
        RSP_ERR,
        RSP_RTY
    } resp_t;

    localparam int unsigned CTRL_IDX      = 0;
    localparam int unsigned STAT_IDX      = 1;
    localparam int unsigned CTRL_IE_BIT   = 0;
    localparam int unsigned CTRL_LOCK_BIT = 1;
    localparam int unsigned STAT_PEND_BIT = 0;

    // The ID register always sits at the top of the map.
    function automatic int unsigned id_index(input int unsigned num_regs);
        return num_regs - 1;
    endfunction

endpackage

// File: rtl/wb_reg_bank.sv
// Register storage for the responder: CTRL/STAT/ID plus general RW words,
// byte-lane writes, read mux and interrupt generation.
module wb_reg_bank
    import wb_pkg_hdl::*;
#(
    parameter int unsigned              DW       = 16,
    parameter int unsigned              NUM_REGS = 16,
    parameter int unsigned              IDX_W    = $clog2(NUM_REGS),
    parameter logic [DW-1:0]            ID_VALUE = 16'hB00C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    input  logic             wr_en,
    input  logic [DW-1:0]    wr_data,
    input  logic [DW/8-1:0]  wr_sel,
    output logic [DW-1:0]    rd_data,
    output logic             lock,
    output logic             inta
);

    localparam logic [IDX_W-1:0] CTRL_I = IDX_W'(CTRL_IDX);
    localparam logic [IDX_W-1:0] STAT_I = IDX_W'(STAT_IDX);
    localparam logic [IDX_W-1:0] ID_I   = IDX_W'(id_index(NUM_REGS));

    logic [DW-1:0] gen_q [NUM_REGS];
    logic          ie_q;
    logic          lock_q;
    logic          pend_q;

    // NOTE: the storage array is reset element by element because a reset is
    // required to clear every register; this keeps it out of RAM inference.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) gen_q[i] <= '0;
            ie_q   <= 1'b0;
            lock_q <= 1'b0;
            pend_q <= 1'b0;
        end else if (wr_en) begin
            if (idx == CTRL_I) begin
                if (wr_sel[0]) begin
                    ie_q   <= wr_data[CTRL_IE_BIT];
                    lock_q <= wr_data[CTRL_LOCK_BIT];
                end
            end else if (idx == STAT_I) begin
                if (wr_sel[0] && wr_data[STAT_PEND_BIT]) pend_q <= 1'b0;
            end else if (idx != ID_I) begin
                for (int b = 0; b < DW/8; b++) begin
                    if (wr_sel[b]) gen_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
                pend_q <= 1'b1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rd_data = '0;
        if (idx == CTRL_I) begin
            rd_data[CTRL_IE_BIT]   = ie_q;
            rd_data[CTRL_LOCK_BIT] = lock_q;
        end else if (idx == STAT_I) begin
            rd_data[STAT_PEND_BIT] = pend_q;
        end else if (idx == ID_I) begin
            rd_data = ID_VALUE;
        end else begin
            rd_data = gen_q[idx];
        end
    end

    assign lock = lock_q;
    assign inta = ie_q & pend_q;

endmodule

// File: rtl/wb_reg_responder.sv
// Wishbone slave with programmable wait states: IDLE/WAIT/RESP FSM, address
// decode and termination selection in front of the register bank.
module wb_reg_responder
    import wb_pkg_hdl::*;
#(
    parameter int unsigned                 WB_ADDR_WIDTH = 32,
    parameter int unsigned                 WB_DATA_WIDTH = 16,
    parameter int unsigned                 NUM_REGS      = 16,
    parameter int unsigned                 WAIT_STATES   = 1,
    parameter logic [WB_DATA_WIDTH-1:0]    ID_VALUE      = 16'hB00C
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cyc,
    input  logic                       stb,
    input  logic                       we,
    input  logic [WB_ADDR_WIDTH-1:0]   adr,
    input  logic [WB_DATA_WIDTH-1:0]   dout,
    input  logic [WB_DATA_WIDTH/8-1:0] sel,
    output logic [WB_DATA_WIDTH-1:0]   din,
    output logic                       ack,
    output logic                       err,
    output logic                       rty,
    output logic                       inta
);

    localparam int unsigned NB      = WB_DATA_WIDTH / 8;
    localparam int unsigned ADR_LSB = $clog2(NB);
    localparam int unsigned IDX_W   = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] CTRL_I = IDX_W'(CTRL_IDX);
    localparam logic [IDX_W-1:0] STAT_I = IDX_W'(STAT_IDX);
    localparam logic [IDX_W-1:0] ID_I   = IDX_W'(id_index(NUM_REGS));
    localparam logic [WB_ADDR_WIDTH-1:0] LOW_MASK = WB_ADDR_WIDTH'((1 << ADR_LSB) - 1);

    state_t                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    resp_t                      resp_q, resp_d;
    logic                       enter_resp;
    logic [WB_ADDR_WIDTH-1:0]   adr_q, req_adr;
    logic                       we_q, req_we;
    logic [WB_DATA_WIDTH-1:0]   dout_q, req_dout;
    logic [NB-1:0]              sel_q, req_sel;
    logic [IDX_W-1:0]           idx;
    logic                       out_of_range, is_gen, lock, wr_en;
    logic [WB_DATA_WIDTH-1:0]   rd_data;

    // With zero wait states the commit happens on the sampling edge itself,
    // so decode must look at the live bus while still in IDLE.
    assign req_adr  = (state_q == ST_IDLE) ? adr  : adr_q;
    assign req_we   = (state_q == ST_IDLE) ? we   : we_q;
    assign req_dout = (state_q == ST_IDLE) ? dout : dout_q;
    assign req_sel  = (state_q == ST_IDLE) ? sel  : sel_q;

    assign idx          = req_adr[ADR_LSB +: IDX_W];
    assign out_of_range = ((req_adr >> (ADR_LSB + IDX_W)) != '0) || ((req_adr & LOW_MASK) != '0);
    assign is_gen       = (idx != CTRL_I) && (idx != STAT_I) && (idx != ID_I);

    always_comb begin
        resp_d = RSP_ACK;
        if (out_of_range || (req_we && idx == ID_I)) resp_d = RSP_ERR;
        else if (req_we && is_gen && lock)           resp_d = RSP_RTY;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cyc && stb) begin
                    if (WAIT_STATES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!cyc) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_en = enter_resp && (resp_d == RSP_ACK) && req_we;

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            resp_q  <= RSP_ACK;
            adr_q   <= '0;
            we_q    <= 1'b0;
            dout_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && cyc && stb) begin
                adr_q  <= adr;
                we_q   <= we;
                dout_q <= dout;
                sel_q  <= sel;
            end
            if (enter_resp) resp_q <= resp_d;
        end
    end

    wb_reg_bank #(
        .DW       (WB_DATA_WIDTH),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .idx     (idx),
        .wr_en   (wr_en),
        .wr_data (req_dout),
        .wr_sel  (req_sel),
        .rd_data (rd_data),
        .lock    (lock),
        .inta    (inta)
    );

    assign ack = (state_q == ST_RESP) && (resp_q == RSP_ACK);
    assign err = (state_q == ST_RESP) && (resp_q == RSP_ERR);
    assign rty = (state_q == ST_RESP) && (resp_q == RSP_RTY);
    assign din = (ack && !we_q) ? rd_data : '0;

endmodule

// File: tb/tb_wb_reg_responder.sv
// Self-checking bench for wb_reg_responder: register-map model plus a
// per-cycle output comparator and directed literal checks.
module tb_wb_reg_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0;
    logic [15:0] dout = '0;
    logic [1:0]  sel = '0;
    logic [15:0] din;
    logic        ack, err, rty, inta;

    wb_reg_responder dut (
        .clk  (clk),  .rst (rst),
        .cyc  (cyc),  .stb (stb), .we (we),
        .adr  (adr),  .dout(dout), .sel(sel),
        .din  (din),  .ack (ack), .err(err), .rty(rty),
        .inta (inta)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected output levels, updated whenever the bus protocol says they change.
    logic        exp_ack = 0, exp_err = 0, exp_rty = 0, exp_inta = 0;
    logic [15:0] exp_din = '0;

    always @(negedge clk) begin
        check("ack",  ack,  exp_ack);
        check("err",  err,  exp_err);
        check("rty",  rty,  exp_rty);
        check("din",  din,  exp_din);
        check("inta", inta, exp_inta);
    end

    // Register-map model: 16 words of 16 bits, 2-byte lanes.
    logic [15:0] m_gen [16];
    logic        m_ie, m_lock, m_pend;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_gen[i] = '0;
        m_ie = 0; m_lock = 0; m_pend = 0;
    endtask

    // term: 1 = ack, 2 = err, 3 = rty
    task automatic model_access(input logic w, input logic [31:0] a, input logic [15:0] d,
                                input logic [1:0] s, output int term, output logic [15:0] rd);
        int i;
        i    = int'(a[4:1]);
        rd   = '0;
        if (a[0] || (a >> 5) != 0)                      term = 2;
        else if (w && i == 15)                          term = 2;
        else if (w && i >= 2 && i <= 14 && m_lock)      term = 3;
        else begin
            term = 1;
            if (w) begin
                if (i == 0) begin
                    if (s[0]) begin m_ie = d[0]; m_lock = d[1]; end
                end else if (i == 1) begin
                    if (s[0] && d[0]) m_pend = 0;
                end else begin
                    if (s[0]) m_gen[i][7:0]  = d[7:0];
                    if (s[1]) m_gen[i][15:8] = d[15:8];
                    m_pend = 1;
                end
            end else begin
                case (i)
                    0:       rd = {14'd0, m_lock, m_ie};
                    1:       rd = {15'd0, m_pend};
                    15:      rd = 16'hB00C;
                    default: rd = m_gen[i];
                endcase
            end
        end
    endtask

    // One bus transfer; returns the termination and read data seen on the bus.
    task automatic txn(input logic w, input logic [31:0] a, input logic [15:0] d,
                       input logic [1:0] s, output int term, output logic [15:0] rd);
        int          m_term;
        logic [15:0] m_rd;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = a; dout = d; sel = s;
        @(posedge clk); #1;             // sampled; now in WAIT
        stb = 0;
        @(posedge clk); #1;             // RESP cycle
        model_access(w, a, d, s, m_term, m_rd);
        exp_ack  = (m_term == 1);
        exp_err  = (m_term == 2);
        exp_rty  = (m_term == 3);
        exp_din  = m_rd;
        exp_inta = m_ie & m_pend;
        @(negedge clk);
        term = ack ? 1 : err ? 2 : rty ? 3 : 0;
        rd   = din;
        @(posedge clk); #1;             // back in IDLE
        cyc = 0; we = 0;
        exp_ack = 0; exp_err = 0; exp_rty = 0; exp_din = '0;
    endtask

    int          t;
    logic [15:0] r;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        check("rst_ack", ack, 0);
        check("rst_din", din, 0);
        #1 rst = 1;

        txn(1, 32'h4, 16'hA5A5, 2'b11, t, r); check("wr_a5a5_term", t, 1);
        txn(0, 32'h4, 16'h0,    2'b11, t, r); check("rd_a5a5_term", t, 1);
        check("rd_a5a5_data", r, 16'hA5A5);

        txn(1, 32'h6, 16'hFFFF, 2'b11, t, r);
        txn(1, 32'h6, 16'h1234, 2'b01, t, r); check("wr_lane0_term", t, 1);
        txn(0, 32'h6, 16'h0,    2'b11, t, r); check("rd_lane0_data", r, 16'hFF34);

        txn(0, 32'h100, 16'h0, 2'b11, t, r);  check("oor_term", t, 2);
        check("oor_din", r, 0);
        txn(0, 32'h5, 16'h0, 2'b11, t, r);    check("misalign_term", t, 2);

        txn(1, 32'h1E, 16'h1111, 2'b11, t, r); check("wr_id_term", t, 2);
        txn(0, 32'h1E, 16'h0,    2'b11, t, r); check("rd_id_data", r, 16'hB00C);

        txn(1, 32'h0, 16'h0002, 2'b11, t, r); check("wr_lock_term", t, 1);
        txn(0, 32'h0, 16'h0,    2'b11, t, r); check("rd_ctrl_data", r, 16'h0002);
        txn(1, 32'h4, 16'h5555, 2'b11, t, r); check("locked_wr_term", t, 3);
        txn(0, 32'h4, 16'h0,    2'b11, t, r); check("locked_unchanged", r, 16'hA5A5);

        txn(1, 32'h0, 16'h0001, 2'b11, t, r);
        txn(1, 32'h8, 16'h0042, 2'b11, t, r); check("pend_wr_term", t, 1);
        check("inta_set", inta, 1);
        txn(0, 32'h2, 16'h0,    2'b11, t, r); check("rd_stat_pend", r, 16'h0001);
        txn(1, 32'h2, 16'h0001, 2'b11, t, r); check("inta_clear", inta, 0);

        // Reset while the transfer sits in WAIT.
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = 32'h4; dout = 16'h7777; sel = 2'b11;
        @(posedge clk); #1;
        rst = 0; stb = 0; cyc = 0; we = 0;
        model_reset();
        exp_inta = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        repeat (2) @(posedge clk);
        txn(0, 32'h4, 16'h0, 2'b11, t, r); check("post_rst_reg2", r, 0);
        txn(0, 32'h6, 16'h0, 2'b11, t, r); check("post_rst_reg3", r, 0);
        txn(0, 32'h0, 16'h0, 2'b11, t, r); check("post_rst_ctrl", r, 0);

        // Abort: cyc drops during WAIT; nothing may be written or terminated.
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = 32'h4; dout = 16'hDEAD; sel = 2'b11;
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
        repeat (3) @(posedge clk);
        txn(0, 32'h4, 16'h0, 2'b11, t, r); check("abort_no_write", r, 0);
        txn(0, 32'h2, 16'h0, 2'b11, t, r); check("abort_no_pend", r, 0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_reg_responder.md
WB_REG_RESPONDER -- requirements
Module: wb_reg_responder

Interface
REQ-001 WB_ADDR_WIDTH, 32, Wishbone address width.
REQ-002 WB_DATA_WIDTH, 16, data width; multiple of 8.
REQ-003 NUM_REGS, 16, register count; power of 2, >=4.
REQ-004 WAIT_STATES, 1, cycles inserted before a response; 0..15.
REQ-005 ID_VALUE, 16'hB00C, constant returned by the ID register.
REQ-006 clk  input  1  bus clock; all state on rising edge.
REQ-007 rst  input  1  reset; one clock, asynchronous, active-low (asserted at 0).
REQ-008 cyc, stb, we  input  1 each  cycle, strobe, write-enable from the master.
REQ-009 adr  input  WB_ADDR_WIDTH  byte address.
REQ-010 dout  input  WB_DATA_WIDTH  master write data.
REQ-011 sel  input  WB_DATA_WIDTH/8  byte selects.
REQ-012 din  output  WB_DATA_WIDTH  read data to the master.
REQ-013 ack, err, rty  output  1 each  termination strobes.
REQ-014 inta  output  1  interrupt request.

Function
REQ-015 Word index = adr[ADR_LSB +: log2(NUM_REGS)], where ADR_LSB = log2(WB_DATA_WIDTH/8); any nonzero adr bit above the index or below ADR_LSB is out of range.
REQ-016 Register map:
- 0 = CTRL, RW: bit0 IE, bit1 LOCK; other bits read 0.
- 1 = STAT: bit0 PEND, write-1-to-clear; other bits read 0.
- 2..NUM_REGS-2 = general RW.
- NUM_REGS-1 = ID, read-only ID_VALUE.
REQ-017 FSM states IDLE, WAIT, RESP; only IDLE samples a new request (cyc&stb=1).
REQ-018 IDLE: on a request at edge N, latch adr/we/dout/sel; go to WAIT with counter=WAIT_STATES-1, or go directly to RESP if WAIT_STATES=0.
REQ-019 WAIT: if cyc=0 at an edge, go to IDLE with no write and no termination (abort); otherwise go to RESP when counter=0, else decrement.
REQ-020 RESP is entered at edge N+WAIT_STATES, lasts exactly one cycle, then goes to IDLE regardless of cyc/stb.
REQ-021 Exactly one of ack/err/rty is 1 while in RESP; all three are 0 in other states.
REQ-022 err when the address is out of range or the access writes ID; rty when LOCK=1 and the access writes a general register; ack otherwise.
REQ-023 Writes commit on the edge entering RESP, only with ack, per byte lane where sel=1.
REQ-024 din = the selected register value during an acked read in RESP; 0 at all other times.
REQ-025 PEND is set by any committed general-register write.
REQ-026 PEND is cleared by an acked write to STAT with dout[0]=1 and sel[0]=1.
REQ-027 inta = IE & PEND (combinational from registers).

Reset
REQ-028 While rst=0:
- state=IDLE, counter=0.
- All registers=0.
- ack=err=rty=0, din=0, inta=0.
REQ-029 Reset mid-transfer discards the transfer; no termination is issued for it after release.
REQ-030 The first request is sampled at the first rising edge after rst returns to 1.

Structure
REQ-031 The state enum and the CTRL/STAT/ID index and bit-position constants belong in wb_pkg_hdl.
REQ-032 One sub-module, wb_reg_bank: register storage, byte-lane write, read mux, PEND/IE logic; the FSM stays in wb_reg_responder.

Verification
REQ-033 Defaults; write 16'hA5A5 to adr 0x4 with sel=2'b11, then read adr 0x4 -> ack high for exactly one cycle, entered 1 edge after the request sample; read returns din=16'hA5A5.
REQ-034 Reg3 holds 16'hFFFF; write 16'h1234 to adr 0x6 with sel=2'b01 -> subsequent read returns 16'hFF34.
REQ-035 Read adr 0x100 -> one-cycle err, ack=0, din=0.
REQ-036 Write to adr 0x1E -> err, and a later read returns 16'hB00C. Write 16'h0002 to adr 0x0, then write 16'h5555 to adr 0x4 -> rty, and reg2 is unchanged.
REQ-037 Write 16'h0001 to CTRL, then write adr 0x8 -> inta=1. Write 16'h0001 to adr 0x2 -> inta=0.
REQ-038 Drive rst=0 during WAIT -> ack/err/rty remain 0 and all registers read 0 afterward. Drop cyc during WAIT -> no termination and no write.
